// File: rtl/pmem_responder_if.sv
// Line-granular pmem bus between an initiator (cache hierarchy) and the
// backing-store responder.
interface pmem_responder_if;
  // Handshake: the initiator raises pmem_read and/or pmem_write with a stable
  // address/wdata and holds them until it sees pmem_resp. The responder raises
  // pmem_resp for exactly one cycle. pmem_rdata is valid in that cycle and is
  // held afterwards. There is no separate ready signal: a request is accepted
  // when the responder samples it in IDLE.
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_resp,
    input  pmem_rdata
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_resp,
    output pmem_rdata
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency line memory behind the pmem bus: one 256-bit read or write
// at a time, answered with a single-cycle pmem_resp pulse.
module pmem_responder #(
  parameter int ADDR_BITS = 9,
  parameter int LATENCY   = 10
) (
  input  logic              clk,
  input  logic              rst,
  pmem_responder_if.slave   pmem,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  logic [1:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [255:0]         wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic [255:0]         rdata_q, rdata_d;
  logic [ADDR_BITS-1:0] req_idx;
  logic                 mem_we;

  // Not reset: contents survive rst and start at zero.
  logic [255:0] mem_q [2**ADDR_BITS];

  logic unused_addr;
  assign unused_addr = ^{pmem.pmem_address[31:ADDR_BITS+5], pmem.pmem_address[4:0]};

  assign req_idx = pmem.pmem_address[ADDR_BITS+4:5];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (pmem.pmem_read || pmem.pmem_write) begin
          idx_d   = req_idx;
          wdata_d = pmem.pmem_wdata;
          wr_d    = pmem.pmem_write;
          rd_d    = pmem.pmem_read;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            // rdata is loaded on the edge that enters RESP, from the live request.
            if (pmem.pmem_write) begin
              if (pmem.pmem_read) rdata_d = pmem.pmem_wdata;
            end else begin
              rdata_d = mem_q[req_idx];
            end
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_RESP;
          if (wr_q) begin
            if (rd_q) rdata_d = wdata_q;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end
      end
      S_RESP: begin
        state_d = S_TURN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  // Commit on the edge that leaves RESP; a coincident reset drops the write.
  assign mem_we = (state_q == S_RESP) && wr_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign pmem.pmem_resp  = (state_q == S_RESP);
  assign pmem.pmem_rdata = rdata_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Line-granular physical memory responder for the `pmem_*` interface driven by `cache_hierarchy`. It accepts one 256-bit line read or write at a time and answers after a fixed, parameterised latency with a single-cycle `pmem_resp` pulse. Storage is an internal line array. It sits below the CPU and cache hierarchy top level as the synthesizable backing store for system-level simulation and FPGA bring-up.

## Interface
- `ADDR_BITS`, default 9: line-index width; array depth is 2^ADDR_BITS lines of 32 bytes each.
- `LATENCY`, default 10: cycles from request acceptance to `pmem_resp`; legal range 1..255.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pmem_read`  in  1  line read request; held high by the initiator until `pmem_resp`.
- `pmem_write`  in  1  line write request; held high by the initiator until `pmem_resp`.
- `pmem_address`  in  32  byte address; bits [4:0] ignored.
- `pmem_wdata`  in  256  write line; byte 0 in bits [7:0].
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_rdata`  out  256  read line; valid in the `pmem_resp` cycle, then held.

## Operation
- FSM states: IDLE, BUSY, RESP, TURN.
- **IDLE**
  - If `pmem_read | pmem_write` is sampled high, accept the request: latch the index `pmem_address[ADDR_BITS+4:5]`, `pmem_wdata` and the op.
  - Load the counter with `LATENCY-1`.
  - Go to BUSY, or to RESP directly if `LATENCY==1`.
- **BUSY**
  - Decrement the counter.
  - Go to RESP when the counter reaches 1 (counter 8 bits, no wrap).
- **RESP**
  - Assert `pmem_resp` for exactly 1 cycle.
  - Read: `pmem_rdata` is driven with `mem[idx]` (registered).
  - Write: `mem[idx] <= wdata_latched` at this edge.
  - Go to TURN.
- **TURN**
  - 1-cycle turnaround; requests are ignored.
  - Go to IDLE.
- Address bits above `ADDR_BITS+4` are ignored, so addresses alias modulo 2^(ADDR_BITS+5) bytes.
- Read and write asserted together: treated as a write. `pmem_rdata` returns the newly written line in the RESP cycle.
- Request inputs changing or dropping after acceptance (a protocol violation): ignored. The latched transaction completes normally.
- Array contents are zero at time 0 and are not cleared by `rst`.

## Timing
- Reset values: `pmem_resp`=0, `pmem_rdata`=256'h0, state=IDLE, counter=0.
- Acceptance edge = edge E0, at which IDLE samples a request.
  - `pmem_resp` is high in the cycle following edge E0+LATENCY-1; i.e. resp is visible LATENCY cycles after the request was first seen.
- Reads and writes have the same latency.
- Minimum request-to-request spacing is LATENCY+2 cycles.
  - The initiator may keep its request high through the TURN cycle without triggering a second transaction.
  - A request still high when IDLE is re-entered is a new transaction.
- `rst` during BUSY or RESP:
  - The transaction is aborted and no write is committed.
  - If the reset edge coincides with the RESP-cycle commit edge, reset wins and the write is dropped.
  - `pmem_resp` goes low the cycle after the `rst` edge.
- `pmem_rdata` holds its last value until the next read's RESP or reset. Write transactions update it only in the simultaneous read/write case.

## Test plan
- **Reset, then write/read back.** Reset for 2 cycles. Write line 256'hA5…A5 to 0x0000_0040, then read 0x0000_0040 → `pmem_resp` pulses exactly LATENCY=10 cycles after each request and `pmem_rdata`=256'hA5…A5.
- **Alignment and aliasing.** Write 256'h1 to 0x0000_0060. Read 0x0000_007F → 256'h1. Read 0x0000_4060 (ADDR_BITS=9) → 256'h1. Read 0x0000_0080 → 0.
- **Back-to-back with held request.** Issue a read and keep `pmem_read` high through the TURN cycle → exactly one resp pulse per LATENCY+2 cycles; no extra pulse during TURN.
- **Simultaneous read/write.** Assert `pmem_read` and `pmem_write` together with 256'hDEAD to 0x100 → resp after LATENCY cycles, `pmem_rdata`=256'hDEAD, and a later read of 0x100 returns 256'hDEAD.
- **Reset mid-transaction.** Start a write of 256'hBEEF to 0x200 and assert `rst` 5 cycles later → no resp; a later read of 0x200 returns the prior contents (0).
- **LATENCY=1 build.** Read/write pairs → resp appears in the cycle after acceptance and data is correct.
